// File: rtl/cic3_sample_fifo_if.sv
// rtl/cic3_sample_fifo_if.sv - valid/ready read port of the decimated sample FIFO
// The master drives the head sample; the slave (readout/SPI side) drives rd_ready.
interface cic3_sample_fifo_if #(
    parameter int DATA_WIDTH = 16
);
    logic                  rd_valid;
    logic                  rd_ready;
    logic [DATA_WIDTH-1:0] rd_data;

    modport master (
        output rd_valid,
        output rd_data,
        input  rd_ready
    );

    modport slave (
        input  rd_valid,
        input  rd_data,
        output rd_ready
    );
endinterface

// File: rtl/cic3_sample_fifo.sv
// rtl/cic3_sample_fifo.sv - CIC3 output capture, offset/scale/saturate, settle discard, sample FIFO
// Everything runs on the modulator clock; the CIC divided clock is only edge-detected.
module cic3_sample_fifo #(
    parameter int IN_WIDTH       = 25,
    parameter int OUT_WIDTH      = 16,
    parameter int FIFO_DEPTH     = 4,
    parameter int SETTLE_SAMPLES = 3
) (
    input  logic                          clk,
    input  logic                          reset_n,
    input  logic [IN_WIDTH-1:0]           cic_out_i,
    input  logic                          cic_div_clk_i,
    input  logic                          enable_i,
    input  logic [IN_WIDTH-1:0]           offset_i,
    input  logic                          overflow_clr_i,
    cic3_sample_fifo_if.master            rd,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count_o,
    output logic                          overflow_o,
    output logic                          sat_flag_o
);
    localparam int PW    = $clog2(FIFO_DEPTH);
    localparam int CW    = PW + 1;
    localparam int SHIFT = IN_WIDTH - OUT_WIDTH;
    localparam int SCW   = (SETTLE_SAMPLES < 2) ? 1 : $clog2(SETTLE_SAMPLES + 1);

    localparam logic signed [IN_WIDTH:0] MIDSCALE = {2'b01, {(IN_WIDTH-1){1'b0}}};
    localparam logic signed [IN_WIDTH:0] SAT_MAX  = {{(SHIFT+2){1'b0}}, {(OUT_WIDTH-1){1'b1}}};
    localparam logic signed [IN_WIDTH:0] SAT_MIN  = {{(SHIFT+2){1'b1}}, {(OUT_WIDTH-1){1'b0}}};
    localparam logic [SCW-1:0] SETTLE_LAST = SCW'((SETTLE_SAMPLES > 0) ? SETTLE_SAMPLES - 1 : 0);
    localparam logic [CW-1:0]  DEPTH_C     = CW'(FIFO_DEPTH);

    typedef enum logic [1:0] {S_IDLE, S_SETTLE, S_RUN} state_t;

    state_t                  state_q, state_d;
    logic [SCW-1:0]          settle_q, settle_d;
    logic                    d1_q, d2_q;
    logic                    fall;
    logic signed [IN_WIDTH:0] c_q, c_d;
    logic                    wr_pend_q;
    logic signed [IN_WIDTH:0] shifted;
    logic [OUT_WIDTH-1:0]    y;
    logic                    sat_hit;

    logic [OUT_WIDTH-1:0]    mem_q [FIFO_DEPTH];
    logic [PW-1:0]           wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]           count_q, count_d;
    logic                    overflow_q, overflow_d, sat_q, sat_d;
    logic                    rd_valid, pop, full, wr_en, push;

    assign fall = d2_q & ~d1_q;

    // Midscale removal and offset subtraction in IN_WIDTH+1 bits cannot overflow.
    assign c_d = $signed({1'b0, cic_out_i}) - MIDSCALE - $signed({offset_i[IN_WIDTH-1], offset_i});

    always_comb begin
        state_d  = state_q;
        settle_d = settle_q;
        case (state_q)
            S_IDLE: begin
                settle_d = '0;
                if (enable_i) begin
                    state_d = (SETTLE_SAMPLES == 0) ? S_RUN : S_SETTLE;
                end
            end
            S_SETTLE: begin
                if (fall) begin
                    if (settle_q == SETTLE_LAST) begin
                        state_d  = S_RUN;
                        settle_d = '0;
                    end else begin
                        settle_d = settle_q + SCW'(1);
                    end
                end
            end
            S_RUN: begin
                settle_d = '0;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
        if (!enable_i) begin
            state_d  = S_IDLE;
            settle_d = '0;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= S_IDLE;
            settle_q  <= '0;
            d1_q      <= 1'b0;
            d2_q      <= 1'b0;
            c_q       <= '0;
            wr_pend_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            settle_q  <= settle_d;
            d1_q      <= cic_div_clk_i;
            d2_q      <= d1_q;
            wr_pend_q <= enable_i & fall & (state_q == S_RUN);
            if (fall && state_q != S_IDLE) begin
                c_q <= c_d;
            end
        end
    end

    always_comb begin
        shifted = c_q >>> SHIFT;
        sat_hit = 1'b0;
        y       = shifted[OUT_WIDTH-1:0];
        if (shifted > SAT_MAX) begin
            y       = SAT_MAX[OUT_WIDTH-1:0];
            sat_hit = 1'b1;
        end else if (shifted < SAT_MIN) begin
            y       = SAT_MIN[OUT_WIDTH-1:0];
            sat_hit = 1'b1;
        end
    end

    assign rd_valid = (count_q != '0);
    assign full     = (count_q == DEPTH_C);
    assign pop      = rd_valid & rd.rd_ready;
    assign wr_en    = wr_pend_q & enable_i;
    // A pop frees the slot in the same cycle, so a full FIFO still accepts.
    assign push     = wr_en & (~full | pop);

    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        overflow_d = (wr_en & full & ~pop) | (overflow_q & ~overflow_clr_i);
        sat_d      = (wr_en & sat_hit) | (sat_q & ~overflow_clr_i);
        if (push) begin
            wr_ptr_d = wr_ptr_q + PW'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PW'(1);
        end
        case ({push, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
        if (!enable_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
            sat_q      <= 1'b0;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
            sat_q      <= sat_d;
            if (push) begin
                mem_q[wr_ptr_q] <= y;
            end
        end
    end

    assign rd.rd_valid  = rd_valid;
    assign rd.rd_data   = rd_valid ? mem_q[rd_ptr_q] : '0;
    assign fifo_count_o = count_q;
    assign overflow_o   = overflow_q;
    assign sat_flag_o   = sat_q;
endmodule

// File: tb/tb_cic3_sample_fifo.sv
// tb/tb_cic3_sample_fifo.sv - self-checking bench for cic3_sample_fifo
module tb_cic3_sample_fifo;
    localparam int IW     = 25;
    localparam int OW     = 16;
    localparam int DEPTH  = 4;
    localparam int SETTLE = 3;

    logic          clk = 1'b0;
    logic          reset_n;
    logic [IW-1:0] cic_out;
    logic          cic_div_clk;
    logic          enable;
    logic [IW-1:0] offset;
    logic          overflow_clr;
    logic [2:0]    fifo_count;
    logic          overflow;
    logic          sat_flag;

    cic3_sample_fifo_if #(.DATA_WIDTH(OW)) rif ();

    cic3_sample_fifo #(
        .IN_WIDTH(IW), .OUT_WIDTH(OW), .FIFO_DEPTH(DEPTH), .SETTLE_SAMPLES(SETTLE)
    ) dut (
        .clk(clk), .reset_n(reset_n), .cic_out_i(cic_out), .cic_div_clk_i(cic_div_clk),
        .enable_i(enable), .offset_i(offset), .overflow_clr_i(overflow_clr), .rd(rif),
        .fifo_count_o(fifo_count), .overflow_o(overflow), .sat_flag_o(sat_flag)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    int q[$];
    bit exp_ovf, exp_sat, en_m;
    int settle_left;

    function automatic int model_y(input logic [IW-1:0] cic, input logic [IW-1:0] off, output bit sat);
        longint c, offs, yv;
        offs = off[IW-1] ? longint'(off) - (longint'(1) << IW) : longint'(off);
        c    = longint'(cic) - (longint'(1) << (IW-1)) - offs;
        yv   = c >>> (IW-OW);
        sat  = 1'b0;
        if (yv > 32767) begin yv = 32767; sat = 1'b1; end
        else if (yv < -32768) begin yv = -32768; sat = 1'b1; end
        return int'(yv);
    endfunction

    task automatic emit(input logic [IW-1:0] val, input int hook);
        int  old, yv;
        bit  popped, s, ovf_set, sat_set;
        logic [OW-1:0] e;
        repeat (2) @(negedge clk);
        cic_out     = val;
        cic_div_clk = 1'b0;
        @(posedge clk); @(negedge clk);
        @(posedge clk); @(negedge clk);
        old = q.size();
        checks++;
        if (fifo_count !== 3'(old) || rif.rd_valid !== (old > 0)) begin
            errors++;
            $display("FAIL pre_write_state: count=%0d valid=%0b expected count=%0d valid=%0b",
                     fifo_count, rif.rd_valid, old, old > 0);
        end
        popped = 1'b0;
        if (hook == 1 && old > 0) begin
            e = OW'(q[0]);
            checks++;
            if (rif.rd_data !== e) begin
                errors++;
                $display("FAIL pop_on_write_data: got %h expected %h", rif.rd_data, e);
            end
            rif.rd_ready = 1'b1;
            popped = 1'b1;
        end
        if (hook == 2) overflow_clr = 1'b1;
        @(posedge clk); @(negedge clk);
        rif.rd_ready = 1'b0;
        overflow_clr = 1'b0;
        if (popped) void'(q.pop_front());
        ovf_set = 1'b0;
        sat_set = 1'b0;
        if (en_m) begin
            if (settle_left > 0) settle_left--;
            else begin
                yv = model_y(val, offset, s);
                sat_set = s;
                if (q.size() < DEPTH) q.push_back(yv);
                else ovf_set = 1'b1;
            end
        end
        if (hook == 2) begin exp_ovf = ovf_set; exp_sat = sat_set; end
        else begin exp_ovf |= ovf_set; exp_sat |= sat_set; end
        checks++;
        if (fifo_count !== 3'(q.size()) || rif.rd_valid !== (q.size() > 0)) begin
            errors++;
            $display("FAIL post_write_state: count=%0d valid=%0b expected count=%0d valid=%0b",
                     fifo_count, rif.rd_valid, q.size(), q.size() > 0);
        end
        checks++;
        if (overflow !== exp_ovf || sat_flag !== exp_sat) begin
            errors++;
            $display("FAIL flags: overflow=%0b sat=%0b expected overflow=%0b sat=%0b",
                     overflow, sat_flag, exp_ovf, exp_sat);
        end
        if (q.size() > 0) begin
            e = OW'(q[0]);
            checks++;
            if (rif.rd_data !== e) begin
                errors++;
                $display("FAIL head_data: got %h expected %h", rif.rd_data, e);
            end
        end
        cic_div_clk = 1'b1;
    endtask

    task automatic pop_one();
        logic [OW-1:0] e;
        @(negedge clk);
        checks++;
        if (rif.rd_valid !== (q.size() > 0)) begin
            errors++;
            $display("FAIL pop_valid: got %0b expected %0b", rif.rd_valid, q.size() > 0);
        end
        if (q.size() > 0) begin
            e = OW'(q[0]);
            checks++;
            if (rif.rd_data !== e) begin
                errors++;
                $display("FAIL pop_data: got %h expected %h", rif.rd_data, e);
            end
        end
        rif.rd_ready = 1'b1;
        @(posedge clk); @(negedge clk);
        rif.rd_ready = 1'b0;
        if (q.size() > 0) void'(q.pop_front());
        checks++;
        if (fifo_count !== 3'(q.size())) begin
            errors++;
            $display("FAIL pop_count: got %0d expected %0d", fifo_count, q.size());
        end
    endtask

    task automatic set_enable(input bit v);
        @(negedge clk);
        enable = v;
        en_m   = v;
        if (v) settle_left = SETTLE;
        else q.delete();
        @(posedge clk); @(negedge clk);
        checks++;
        if (fifo_count !== 3'(q.size()) || rif.rd_valid !== (q.size() > 0)) begin
            errors++;
            $display("FAIL enable_%0b_state: count=%0d valid=%0b expected count=%0d",
                     v, fifo_count, rif.rd_valid, q.size());
        end
    endtask

    task automatic pulse_clr();
        @(negedge clk);
        overflow_clr = 1'b1;
        @(posedge clk); @(negedge clk);
        overflow_clr = 1'b0;
        exp_ovf = 1'b0;
        exp_sat = 1'b0;
        checks++;
        if (overflow !== 1'b0 || sat_flag !== 1'b0) begin
            errors++;
            $display("FAIL clear_flags: overflow=%0b sat=%0b expected 0 0", overflow, sat_flag);
        end
    endtask

    task automatic test_reset();
        reset_n = 1'b0; enable = 1'b0; cic_out = '0; cic_div_clk = 1'b1;
        offset = '0; overflow_clr = 1'b0; rif.rd_ready = 1'b0;
        en_m = 1'b0; exp_ovf = 1'b0; exp_sat = 1'b0; settle_left = 0;
        repeat (3) @(negedge clk);
        checks++;
        if (rif.rd_valid !== 1'b0 || rif.rd_data !== '0 || fifo_count !== '0 || overflow !== 1'b0 || sat_flag !== 1'b0) begin
            errors++;
            $display("FAIL reset_outputs: valid=%0b data=%h count=%0d ovf=%0b sat=%0b expected all 0",
                     rif.rd_valid, rif.rd_data, fifo_count, overflow, sat_flag);
        end
        reset_n = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_first_sample();
        set_enable(1'b1);
        for (int i = 0; i < SETTLE; i++) emit(25'h1000000 + 25'(i * 4096), 0);
        emit(25'h1000000, 0);
        pop_one();
    endtask

    task automatic test_saturation();
        offset = '0;
        emit(25'h1FFFFFF, 0);
        emit(25'h0000000, 0);
        pop_one(); pop_one();
        offset = 25'h1F00000;
        emit(25'h1FFFFFF, 0);
        pop_one();
        pulse_clr();
        offset = 25'h0100000;
        emit(25'h0000000, 0);
        pop_one();
        pulse_clr();
    endtask

    task automatic test_offset();
        offset = 25'h0000200;
        emit(25'h1000000, 0);
        pop_one();
        pop_one();
        offset = '0;
    endtask

    task automatic test_overflow();
        for (int i = 0; i < 6; i++) emit(25'h1000000 + 25'(i * 1000), 0);
        pulse_clr();
        emit(25'h0F00000, 1);
        for (int i = 0; i < DEPTH; i++) pop_one();
    endtask

    task automatic test_disable();
        emit(25'h1234567, 0);
        emit(25'h0ABCDEF, 0);
        set_enable(1'b0);
        set_enable(1'b1);
        for (int i = 0; i < SETTLE; i++) emit(25'h1800000, 0);
        emit(25'h0800000, 0);
        pop_one();
    endtask

    task automatic test_reset_mid_capture();
        for (int i = 0; i < 5; i++) emit(25'h1000000 - 25'(i * 999), 0);
        repeat (2) @(negedge clk);
        cic_out = 25'h1555555;
        cic_div_clk = 1'b0;
        @(posedge clk);
        #2 reset_n = 1'b0;
        #1;
        checks++;
        if (rif.rd_valid !== 1'b0 || rif.rd_data !== '0 || fifo_count !== '0 || overflow !== 1'b0 || sat_flag !== 1'b0) begin
            errors++;
            $display("FAIL async_reset: valid=%0b data=%h count=%0d ovf=%0b sat=%0b expected all 0",
                     rif.rd_valid, rif.rd_data, fifo_count, overflow, sat_flag);
        end
        @(negedge clk);
        cic_div_clk = 1'b1;
        @(negedge clk);
        reset_n = 1'b1;
        q.delete();
        exp_ovf = 1'b0; exp_sat = 1'b0; settle_left = SETTLE;
    endtask

    task automatic test_clr_collision();
        for (int i = 0; i < SETTLE + DEPTH; i++) emit(25'h0C00000 + 25'(i), 0);
        emit(25'h0C00000, 2);
        pulse_clr();
        for (int i = 0; i < DEPTH; i++) pop_one();
    endtask

    task automatic test_random();
        for (int i = 0; i < 40; i++) begin
            case ($urandom % 4)
                0: pop_one();
                1: offset = 25'($urandom_range(0, 1 << 22)) - 25'(1 << 21);
                default: emit(25'($urandom), int'($urandom % 2));
            endcase
        end
        while (q.size() > 0) pop_one();
        pop_one();
    endtask

    initial begin
        test_reset();
        test_first_sample();
        test_saturation();
        test_offset();
        test_overflow();
        test_disable();
        test_reset_mid_capture();
        test_clr_collision();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
